// File: rtl/nfc_page_reader.sv
// Source-side NAND page read engine: issues 00h plus three address cycles to flash A,
// waits on R/B, then streams PAGE_BYTES bytes on valid/ready. Define RB_TIMEOUT_EN for the R/B watchdog.
module nfc_page_reader #(
  parameter int PAGE_BYTES  = 512,
  parameter int TWB_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] page,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  inout  wire  [7:0] F_IO_A,
  output logic       F_CLE_A,
  output logic       F_ALE_A,
  output logic       F_REN_A,
  output logic       F_WEN_A,
  input  logic       F_RB_A
);

  // state    | meaning
  // IDLE     | waiting for start
  // CMD      | read command 00h write cycle (2 phases)
  // ADDR0..2 | column, page low, page high address cycles
  // TWB      | R/B ignored after the last WE# rising edge
  // WAIT_RDY | waiting for R/B high
  // RD_LO    | RE# low, flash drives the next byte
  // RD_HI    | RE# high, waiting for the output register to drain
  // DONE     | done pulse
  // ERR      | watchdog abort, err pulse

  localparam int CNT_W = $clog2(PAGE_BYTES) + 1;
  localparam int TWB_W = (TWB_CYC > 1) ? $clog2(TWB_CYC) : 1;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR0, ADDR1, ADDR2, TWB, WAIT_RDY, RD_LO, RD_HI, DONE, ERR
  } state_t;

  state_t             state;
  logic               phase;
  logic [8:0]         page_q;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TWB_W-1:0]   twb_cnt;
  logic [7:0]         io_q;
  logic               io_oe;
  logic               hs;
  logic               last_byte;

  assign hs        = data_valid && data_ready;
  assign last_byte = (byte_cnt == CNT_W'(PAGE_BYTES));
  assign F_IO_A    = io_oe ? io_q : 8'bz;

`ifdef RB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt;
`else
  // Watchdog compiled out: err is constant low.
  assign err = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      page_q     <= '0;
      byte_cnt   <= '0;
      twb_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
      F_CLE_A    <= 1'b0;
      F_ALE_A    <= 1'b0;
      F_REN_A    <= 1'b1;
      F_WEN_A    <= 1'b1;
      io_q       <= 8'h00;
      io_oe      <= 1'b0;
`ifdef RB_TIMEOUT_EN
      err        <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RB_TIMEOUT_EN
      err  <= 1'b0;
`endif
      // Write-cycle pins are decoded from the current state, so they trail it by one cycle.
      F_CLE_A <= 1'b0;
      F_ALE_A <= 1'b0;
      F_WEN_A <= 1'b1;
      io_oe   <= 1'b0;
      case (state)
        CMD: begin
          F_CLE_A <= 1'b1;
          F_WEN_A <= phase;
          io_q    <= 8'h00;
          io_oe   <= 1'b1;
        end
        ADDR0: begin
          F_ALE_A <= 1'b1;
          F_WEN_A <= phase;
          io_q    <= 8'h00;
          io_oe   <= 1'b1;
        end
        ADDR1: begin
          F_ALE_A <= 1'b1;
          F_WEN_A <= phase;
          io_q    <= page_q[7:0];
          io_oe   <= 1'b1;
        end
        ADDR2: begin
          F_ALE_A <= 1'b1;
          F_WEN_A <= phase;
          io_q    <= {7'b0, page_q[8]};
          io_oe   <= 1'b1;
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            page_q <= page;
            busy   <= 1'b1;
            phase  <= 1'b0;
            state  <= CMD;
          end
        end
        CMD: begin
          phase <= ~phase;
          if (phase) state <= ADDR0;
        end
        ADDR0: begin
          phase <= ~phase;
          if (phase) state <= ADDR1;
        end
        ADDR1: begin
          phase <= ~phase;
          if (phase) state <= ADDR2;
        end
        ADDR2: begin
          phase <= ~phase;
          if (phase) begin
            state   <= TWB;
            twb_cnt <= TWB_W'(TWB_CYC - 1);
          end
        end
        TWB: begin
          if (twb_cnt == '0) begin
            state  <= WAIT_RDY;
`ifdef RB_TIMEOUT_EN
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
`endif
          end else begin
            twb_cnt <= twb_cnt - TWB_W'(1);
          end
        end
        WAIT_RDY: begin
          if (F_RB_A) begin
            state    <= RD_LO;
            F_REN_A  <= 1'b0;
            byte_cnt <= '0;
          end
`ifdef RB_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            state      <= ERR;
            err        <= 1'b1;
            busy       <= 1'b0;
            data_valid <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
`endif
        end
        RD_LO: begin
          F_REN_A    <= 1'b1;
          data_out   <= F_IO_A;
          data_valid <= 1'b1;
          byte_cnt   <= byte_cnt + CNT_W'(1);
          state      <= RD_HI;
        end
        RD_HI: begin
          if (hs) data_valid <= 1'b0;
          if (last_byte) begin
            if (hs) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else if (!data_valid || data_ready) begin
            state   <= RD_LO;
            F_REN_A <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
